// File: rtl/serial_word_adder_pkg.sv
// Shared types and sizing helpers for the serial word adder.
// Imported by serial_word_adder (optional subtract mode: SERIAL_WORD_ADDER_SUB_EN).
package serial_word_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Number of RUN cycles needed to consume a full word.
    function automatic int calc_n(input int width, input int digit);
        return width / digit;
    endfunction

    // Counter width; the +1 keeps a valid width when N == 1.
    function automatic int calc_cnt_w(input int n);
        return $clog2(n) + 1;
    endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational DIGIT-bit ripple-carry slice used once per clock by the serial adder.
module serial_digit_adder #(
    parameter int DIGIT = 1
) (
    input  logic [DIGIT-1:0] a_d,
    input  logic [DIGIT-1:0] b_d,
    input  logic             c_in,
    output logic [DIGIT-1:0] s_d,
    output logic             c_out
);

    logic [DIGIT:0] carry;

    assign carry[0] = c_in;

    for (genvar gi = 0; gi < DIGIT; gi++) begin : g_bit
        assign s_d[gi]       = a_d[gi] ^ b_d[gi] ^ carry[gi];
        assign carry[gi + 1] = (a_d[gi] & b_d[gi]) | (carry[gi] & (a_d[gi] ^ b_d[gi]));
    end

    assign c_out = carry[DIGIT];

endmodule

// File: rtl/serial_word_adder.sv
// Handshaked word adder that adds DIGIT bits per clock through a single carry flop.
// Define SERIAL_WORD_ADDER_SUB_EN to add the 'sub' port (a - b - cin, cout reports borrow).
module serial_word_adder
    import serial_word_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef SERIAL_WORD_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
);

    localparam int N  = calc_n(WIDTH, DIGIT);
    localparam int CW = calc_cnt_w(N);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_param_check
        $fatal(1, "serial_word_adder: DIGIT must be >= 1 and divide WIDTH exactly");
    end

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  a_q, a_d;
    logic [WIDTH-1:0]  b_q, b_d;
    logic [WIDTH-1:0]  sum_q, sum_d;
    logic              carry_q, carry_d;
    logic              cout_q, cout_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              sub_q, sub_d;
    logic              sub_in;

`ifdef SERIAL_WORD_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    logic [DIGIT-1:0]  dig_s;
    logic              dig_c;

    serial_digit_adder #(
        .DIGIT (DIGIT)
    ) u_digit (
        .a_d   (a_q[DIGIT-1:0]),
        .b_d   (b_q[DIGIT-1:0]),
        .c_in  (carry_q),
        .s_d   (dig_s),
        .c_out (dig_c)
    );

    // Shifted views; with a single digit the whole word is consumed in one step.
    logic [WIDTH-1:0] a_shr, b_shr, sum_ins;

    if (N == 1) begin : g_single
        assign a_shr   = '0;
        assign b_shr   = '0;
        assign sum_ins = dig_s;
    end else begin : g_multi
        assign a_shr   = {{DIGIT{1'b0}}, a_q[WIDTH-1:DIGIT]};
        assign b_shr   = {{DIGIT{1'b0}}, b_q[WIDTH-1:DIGIT]};
        assign sum_ins = {dig_s, sum_q[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
            sub_q   <= sub_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;
        sub_d   = sub_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtraction is a + ~b + ~cin; the final carry is inverted into a borrow.
                    a_d     = a;
                    b_d     = sub_in ? ~b : b;
                    carry_d = sub_in ? ~cin : cin;
                    sub_d   = sub_in;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_shr;
                b_d     = b_shr;
                sum_d   = sum_ins;
                carry_d = dig_c;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    cout_d  = sub_q ? ~dig_c : dig_c;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q == RUN);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;

endmodule

// File: tb/tb_serial_word_adder.sv
// Directed bench for serial_word_adder: 8/1, 16/4 and 1/1 (single-digit) configurations.
module tb_serial_word_adder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // WIDTH=8, DIGIT=1
    logic       iv8, ir8, cin8, ov8, or8, co8, bz8, sub8;
    logic [7:0] a8, b8, s8;
    // WIDTH=16, DIGIT=4
    logic        iv16, ir16, cin16, ov16, or16, co16, bz16;
    logic [15:0] a16, b16, s16;
    // WIDTH=1, DIGIT=1
    logic iv1, ir1, cin1, ov1, or1, co1, bz1;
    logic [0:0] a1, b1, s1;

    serial_word_adder #(.WIDTH(8), .DIGIT(1)) u8 (
        .clk(clk), .reset(reset), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8), .cin(cin8),
`ifdef SERIAL_WORD_ADDER_SUB_EN
        .sub(sub8),
`endif
        .out_valid(ov8), .out_ready(or8), .sum(s8), .cout(co8), .busy(bz8)
    );

    serial_word_adder #(.WIDTH(16), .DIGIT(4)) u16 (
        .clk(clk), .reset(reset), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16), .cin(cin16),
`ifdef SERIAL_WORD_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov16), .out_ready(or16), .sum(s16), .cout(co16), .busy(bz16)
    );

    serial_word_adder #(.WIDTH(1), .DIGIT(1)) u1 (
        .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .a(a1), .b(b1), .cin(cin1),
`ifdef SERIAL_WORD_ADDER_SUB_EN
        .sub(1'b0),
`endif
        .out_valid(ov1), .out_ready(or1), .sum(s1), .cout(co1), .busy(bz1)
    );

    // Drivers: called at posedge+1 with the DUT idle; return once out_valid is seen
    // (or the cycle budget runs out). lat counts clock edges after the accepting edge.
    task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                       output int lat, output int bc);
        a8 = a; b8 = b; cin8 = c; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        lat = 0; bc = 0;
        while (ov8 !== 1'b1 && lat < 50) begin
            if (bz8 === 1'b1) bc++;
            @(posedge clk); #1;
            lat++;
        end
        $display("op8  a=%h b=%h cin=%0d sub=%0d -> sum=%h cout=%0d lat=%0d", a, b, c, sub8, s8, co8, lat);
    endtask

    task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic c, output int lat);
        a16 = a; b16 = b; cin16 = c; iv16 = 1'b1;
        @(posedge clk); #1;
        iv16 = 1'b0;
        lat = 0;
        while (ov16 !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("op16 a=%h b=%h cin=%0d -> sum=%h cout=%0d lat=%0d", a, b, c, s16, co16, lat);
    endtask

    task automatic op1(input logic a, input logic b, input logic c, output int lat);
        a1 = a; b1 = b; cin1 = c; iv1 = 1'b1;
        @(posedge clk); #1;
        iv1 = 1'b0;
        lat = 0;
        while (ov1 !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        $display("op1  a=%0d b=%0d cin=%0d -> sum=%0d cout=%0d lat=%0d", a, b, c, s1, co1, lat);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        checks++; if (ir8 !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", ir8); end
        checks++; if (ov8 !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", ov8); end
        checks++; if (s8 !== 8'h00) begin errors++; $display("FAIL reset_sum: got %h want 00", s8); end
        checks++; if (co8 !== 1'b0) begin errors++; $display("FAIL reset_cout: got %b want 0", co8); end
        checks++; if (bz8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bz8); end
        checks++; if (ir16 !== 1'b1 || ov16 !== 1'b0 || s16 !== 16'h0 || co16 !== 1'b0 || bz16 !== 1'b0) begin
            errors++; $display("FAIL reset_u16: got ir=%b ov=%b sum=%h cout=%b busy=%b want 1 0 0000 0 0",
                               ir16, ov16, s16, co16, bz16);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic8();
        int lat, bc;
        op8(8'h3C, 8'h0F, 1'b0, lat, bc);
        // accept clock + 8 RUN clocks = out_valid 8 edges after the accepting edge
        checks++; if (lat !== 8) begin errors++; $display("FAIL basic8_latency: got %0d want 8", lat); end
        checks++; if (s8 !== 8'h4B) begin errors++; $display("FAIL basic8_sum: got %h want 4b", s8); end
        checks++; if (co8 !== 1'b0) begin errors++; $display("FAIL basic8_cout: got %b want 0", co8); end
        @(posedge clk); #1;
        checks++; if (ov8 !== 1'b0 || ir8 !== 1'b1) begin
            errors++; $display("FAIL basic8_handshake: got ov=%b ir=%b want 0 1", ov8, ir8);
        end
    endtask

    task automatic test_carry8();
        int lat, bc;
        op8(8'hFF, 8'h01, 1'b1, lat, bc);
        checks++; if (s8 !== 8'h01) begin errors++; $display("FAIL carry8_sum: got %h want 01", s8); end
        checks++; if (co8 !== 1'b1) begin errors++; $display("FAIL carry8_cout: got %b want 1", co8); end
        checks++; if (bc !== 8) begin errors++; $display("FAIL carry8_busy_cycles: got %0d want 8", bc); end
        @(posedge clk); #1;
    endtask

    task automatic test_digit4();
        int lat;
        op16(16'hFFFF, 16'h0000, 1'b1, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL digit4_latency: got %0d want 4", lat); end
        checks++; if (s16 !== 16'h0000) begin errors++; $display("FAIL digit4_sum: got %h want 0000", s16); end
        checks++; if (co16 !== 1'b1) begin errors++; $display("FAIL digit4_cout: got %b want 1", co16); end
        @(posedge clk); #1;
        op16(16'h1234, 16'h0FCD, 1'b1, lat);
        checks++; if (s16 !== 16'h2202 || co16 !== 1'b0) begin
            errors++; $display("FAIL digit4_mixed: got sum=%h cout=%b want 2202 0", s16, co16);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_backpressure();
        int lat, bc, n;
        or8 = 1'b0;
        op8(8'h12, 8'h34, 1'b1, lat, bc);
        checks++; if (s8 !== 8'h47 || co8 !== 1'b0) begin
            errors++; $display("FAIL bp_result: got sum=%h cout=%b want 47 0", s8, co8);
        end
        a8 = 8'hAA; b8 = 8'h11; cin8 = 1'b0; iv8 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            checks++; if (s8 !== 8'h47 || co8 !== 1'b0 || ir8 !== 1'b0 || ov8 !== 1'b1) begin
                errors++; $display("FAIL bp_hold[%0d]: got sum=%h cout=%b ir=%b ov=%b want 47 0 0 1",
                                   i, s8, co8, ir8, ov8);
            end
        end
        or8 = 1'b1;
        @(posedge clk); #1;
        checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0 || bz8 !== 1'b0) begin
            errors++; $display("FAIL bp_release: got ir=%b ov=%b busy=%b want 1 0 0", ir8, ov8, bz8);
        end
        @(posedge clk); #1;
        iv8 = 1'b0;
        checks++; if (bz8 !== 1'b1) begin errors++; $display("FAIL bp_new_accept: got busy=%b want 1", bz8); end
        n = 0;
        while (ov8 !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        checks++; if (n !== 8 || s8 !== 8'hBB || co8 !== 1'b0) begin
            errors++; $display("FAIL bp_second: got lat=%0d sum=%h cout=%b want 8 bb 0", n, s8, co8);
        end
        $display("op8  a=aa b=11 cin=0 (queued) -> sum=%h cout=%0d lat=%0d", s8, co8, n);
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        a8 = 8'hF0; b8 = 8'h0F; cin8 = 1'b1; iv8 = 1'b1;
        @(posedge clk); #1;
        iv8 = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++; if (ir8 !== 1'b1 || ov8 !== 1'b0 || s8 !== 8'h00 || co8 !== 1'b0 || bz8 !== 1'b0) begin
            errors++; $display("FAIL midreset_state: got ir=%b ov=%b sum=%h cout=%b busy=%b want 1 0 00 0 0",
                               ir8, ov8, s8, co8, bz8);
        end
        reset = 1'b0;
        @(posedge clk); #1;
        op8(8'h01, 8'h02, 1'b0, lat, bc);
        checks++; if (lat !== 8 || s8 !== 8'h03 || co8 !== 1'b0) begin
            errors++; $display("FAIL midreset_next_op: got lat=%0d sum=%h cout=%b want 8 03 0", lat, s8, co8);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width1();
        int lat;
        op1(1'b1, 1'b1, 1'b1, lat);
        checks++; if (lat !== 1) begin errors++; $display("FAIL w1_latency: got %0d want 1", lat); end
        checks++; if (s1 !== 1'b1 || co1 !== 1'b1) begin
            errors++; $display("FAIL w1_111: got sum=%b cout=%b want 1 1", s1, co1);
        end
        @(posedge clk); #1;
        op1(1'b1, 1'b0, 1'b0, lat);
        checks++; if (s1 !== 1'b1 || co1 !== 1'b0) begin
            errors++; $display("FAIL w1_100: got sum=%b cout=%b want 1 0", s1, co1);
        end
        @(posedge clk); #1;
    endtask

`ifdef SERIAL_WORD_ADDER_SUB_EN
    task automatic test_sub();
        int lat, bc;
        sub8 = 1'b1;
        op8(8'h05, 8'h07, 1'b0, lat, bc);
        checks++; if (s8 !== 8'hFE || co8 !== 1'b1) begin
            errors++; $display("FAIL sub_diff: got sum=%h borrow=%b want fe 1", s8, co8);
        end
        @(posedge clk); #1;
        sub8 = 1'b0;
        op8(8'h05, 8'h07, 1'b0, lat, bc);
        checks++; if (s8 !== 8'h0C || co8 !== 1'b0) begin
            errors++; $display("FAIL sub_off_add: got sum=%h cout=%b want 0c 0", s8, co8);
        end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        iv8 = 0; a8 = '0; b8 = '0; cin8 = 0; or8 = 1; sub8 = 0;
        iv16 = 0; a16 = '0; b16 = '0; cin16 = 0; or16 = 1;
        iv1 = 0; a1 = '0; b1 = '0; cin1 = 0; or1 = 1;
        test_reset();
        test_basic8();
        test_carry8();
        test_digit4();
        test_backpressure();
        test_reset_mid();
        test_width1();
`ifdef SERIAL_WORD_ADDER_SUB_EN
        test_sub();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
